fir_out_requant: RTL

Downstream output stage of the FIR filter. Accepts the full-precision signed product-sum (`2*DATA_WIDTH` bits) with its valid strobe, applies round-half-up arithmetic right shift, saturates to sample width, and optionally decimates. Results are buffered in a small FIFO and presented to the consumer over a ready/valid handshake. Sticky flags report saturation and FIFO overflow.

---
 rtl/fir_pkg.sv | 26 ++
 rtl/sync_fifo.sv | 61 ++++++
 rtl/fir_out_requant.sv | 130 +++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared constants and arithmetic helpers for the FIR filter datapath.
package fir_pkg;

  localparam int SAMPLE_W = 16;
  localparam int ACC_W    = 32;

  // Clamp a signed value into the signed range of 'width' bits. The result
  // keeps the full argument width; the caller takes the low 'width' bits.
  function automatic logic signed [ACC_W:0] sat_trunc(
    input logic signed [ACC_W:0] value,
    input int                    width
  );
    logic signed [ACC_W:0] hi;
    logic signed [ACC_W:0] lo;
    hi = ({{ACC_W{1'b0}}, 1'b1} << (width - 1)) - {{ACC_W{1'b0}}, 1'b1};
    lo = ~hi;
    if (value > hi) begin
      return hi;
    end else if (value < lo) begin
      return lo;
    end else begin
      return value;
    end
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage and an occupancy count.
// Pop on an empty FIFO is ignored; push on a full FIFO succeeds only when
// a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (level == FULL_LVL);
  assign empty    = (level == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // Storage: cleared on reset so the head reads zero until the first write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/fir_out_requant.sv
// FIR output stage: round-half-up shift, saturate, decimate, buffer.
//
// Output handshake: out_valid is high whenever the FIFO holds a sample and
// out_data is the oldest one. A sample is consumed at a rising edge where
// out_valid && out_ready; while out_valid && !out_ready, out_data holds.
// out_ready has no effect while out_valid is low. Upstream has no
// backpressure: a kept sample arriving at a full, non-popping FIFO is lost
// and recorded in ovf_flag.
module fir_out_requant
  import fir_pkg::*;
#(
  parameter int IN_WIDTH   = ACC_W,
  parameter int OUT_WIDTH  = SAMPLE_W,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [IN_WIDTH-1:0]           in_data,
  input  logic                          in_valid,
  input  logic [4:0]                    shift,
  input  logic [3:0]                    decim,
  output logic [OUT_WIDTH-1:0]          out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          sat_flag,
  output logic                          ovf_flag,
  input  logic                          clear_flags
);

  logic signed [IN_WIDTH:0]  in_ext;
  logic signed [IN_WIDTH:0]  rnd;
  logic signed [IN_WIDTH:0]  sum1;
  logic signed [IN_WIDTH:0]  r1;
  logic                      s1_valid;
  logic signed [IN_WIDTH:0]  s1_data;
  logic signed [ACC_W:0]     s1_wide;
  logic signed [ACC_W:0]     sat_v;
  logic                      s2_valid;
  logic [OUT_WIDTH-1:0]      s2_data;
  logic                      s2_sat;
  logic [3:0]                phase;
  logic                      phase_last;
  logic                      keep;
  logic                      pop;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      drop;

  // Rounding shift, one bit wider than the input so the rounding add never wraps.
  always_comb begin
    in_ext = {in_data[IN_WIDTH-1], in_data};
    rnd    = '0;
    if (shift != 5'd0) rnd = (IN_WIDTH+1)'(1) << (shift - 5'd1);
    sum1   = in_ext + rnd;
    r1     = sum1 >>> shift;
  end

  // Stage 1 register: rounded and shifted value.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= in_valid;
    end
    if (in_valid) s1_data <= r1;
  end

  assign s1_wide = (ACC_W+1)'(s1_data);
  assign sat_v   = sat_trunc(s1_wide, OUT_WIDTH);

  // Stage 2 register: saturated sample plus a note that clamping happened.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
    end
    if (s1_valid) begin
      s2_data <= sat_v[OUT_WIDTH-1:0];
      s2_sat  <= (sat_v != s1_wide);
    end
  end

  // Decimation: keep the sample seen at phase zero; >= tolerates decim shrinking mid-stream.
  assign phase_last = (decim <= 4'd1) || (phase >= decim - 4'd1);
  assign keep       = s2_valid && (phase == 4'd0);

  // Phase counter advances once per stage-2 sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= 4'd0;
    end else if (s2_valid) begin
      phase <= phase_last ? 4'd0 : phase + 4'd1;
    end
  end

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign drop      = keep && fifo_full && !pop;

  sync_fifo #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (keep),
    .push_data (s2_data),
    .pop       (pop),
    .pop_data  (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  // Sticky flags; a set event in the same cycle takes priority over clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_flag <= 1'b0;
      ovf_flag <= 1'b0;
    end else begin
      if (keep && s2_sat)   sat_flag <= 1'b1;
      else if (clear_flags) sat_flag <= 1'b0;
      if (drop)             ovf_flag <= 1'b1;
      else if (clear_flags) ovf_flag <= 1'b0;
    end
  end

endmodule
